// File: rtl/pwm_capture.sv
// PWM input capture: measures period (rise to rise) and high time of pwm_in in clk
// cycles, flags a stalled input as stuck along with the level it stalled at.
module pwm_capture #(
  parameter int WIDTH       = 24,
  parameter int SYNC_STAGES = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             pwm_in,
  output logic [WIDTH-1:0] cap_period,
  output logic [WIDTH-1:0] cap_high,
  output logic             cap_valid,
  output logic             stuck,
  output logic             stuck_level
);

  typedef enum logic [1:0] {ARM, HIGH, LOW} state_t;

  localparam logic [WIDTH-1:0] CNT_MAX = '1;

  logic [SYNC_STAGES-1:0] sync;
  logic                   s, s_d, rise, fall;

  state_t           state, state_nxt;
  logic [WIDTH-1:0] cnt, cnt_nxt, cnt_inc;
  logic [WIDTH-1:0] high_lat, high_lat_nxt;
  logic [WIDTH-1:0] period_nxt, high_nxt;
  logic             valid_nxt, stuck_nxt, level_nxt;

  always_ff @(posedge clk) begin
    if (rst) begin
      sync <= '0;
      s_d  <= 1'b0;
    end else begin
      sync <= {sync[SYNC_STAGES-2:0], pwm_in};
      s_d  <= s;
    end
  end

  assign s    = sync[SYNC_STAGES-1];
  assign rise = s & ~s_d;
  assign fall = ~s & s_d;

  // Saturate so a fall landing on the last count cannot wrap into LOW;
  // the timeout then fires on the following cycle.
  assign cnt_inc = (cnt == CNT_MAX) ? cnt : cnt + WIDTH'(1);

  always_comb begin
    state_nxt    = state;
    cnt_nxt      = cnt;
    high_lat_nxt = high_lat;
    period_nxt   = cap_period;
    high_nxt     = cap_high;
    valid_nxt    = 1'b0;
    stuck_nxt    = stuck;
    level_nxt    = stuck_level;
    unique case (state)
      ARM: begin
        cnt_nxt = '0;
        if (rise) begin
          cnt_nxt   = WIDTH'(1);
          state_nxt = HIGH;
        end
      end
      HIGH: begin
        if (fall) begin
          high_lat_nxt = cnt;
          cnt_nxt      = cnt_inc;
          state_nxt    = LOW;
        end else if (cnt == CNT_MAX) begin
          stuck_nxt = 1'b1;
          level_nxt = s;
          cnt_nxt   = '0;
          state_nxt = ARM;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      LOW: begin
        if (rise) begin
          period_nxt = cnt;
          high_nxt   = high_lat;
          valid_nxt  = 1'b1;
          stuck_nxt  = 1'b0;
          cnt_nxt    = WIDTH'(1);
          state_nxt  = HIGH;
        end else if (cnt == CNT_MAX) begin
          stuck_nxt = 1'b1;
          level_nxt = s;
          cnt_nxt   = '0;
          state_nxt = ARM;
        end else begin
          cnt_nxt = cnt_inc;
        end
      end
      default: begin
        cnt_nxt   = '0;
        state_nxt = ARM;
      end
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ARM;
      cnt         <= '0;
      high_lat    <= '0;
      cap_period  <= '0;
      cap_high    <= '0;
      cap_valid   <= 1'b0;
      stuck       <= 1'b0;
      stuck_level <= 1'b0;
    end else begin
      state       <= state_nxt;
      cnt         <= cnt_nxt;
      high_lat    <= high_lat_nxt;
      cap_period  <= period_nxt;
      cap_high    <= high_nxt;
      cap_valid   <= valid_nxt;
      stuck       <= stuck_nxt;
      stuck_level <= level_nxt;
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Bench for pwm_capture: directed waveforms plus random segments, checked every cycle
// against a timestamp model of rise/fall times on the synchronized input.
module tb_pwm_capture;

  localparam int W    = 8;
  localparam int S    = 2;
  localparam int MAXC = (1 << W) - 1;

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         pwm_in = 1'b0;
  logic [W-1:0] cap_period, cap_high;
  logic         cap_valid, stuck, stuck_level;

  pwm_capture #(.WIDTH(W), .SYNC_STAGES(S)) dut (
    .clk(clk), .rst(rst), .pwm_in(pwm_in),
    .cap_period(cap_period), .cap_high(cap_high), .cap_valid(cap_valid),
    .stuck(stuck), .stuck_level(stuck_level)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Input history, indexed by the clock edge that sampled it.
  bit hist [0:65535];
  int m = 0;

  // Model: times of last rise and of the fall after it, in input-index units.
  bit running = 0, fvalid = 0;
  int r_t = 0, f_t = 0;
  int e_period = 0, e_high = 0;
  bit e_valid = 0, e_stuck = 0, e_lvl = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s cycle=%0d observed=%0d expected=%0d", tag, m, obs, exp);
    end
  endtask

  task automatic model(input bit r);
    int t;
    bit cur, prv;
    e_valid = 0;
    if (r) begin
      for (int j = m - S; j <= m; j++) if (j >= 0) hist[j] = 0;
      running = 0; fvalid = 0;
      e_period = 0; e_high = 0; e_stuck = 0; e_lvl = 0;
      return;
    end
    t   = m - S;
    cur = (t >= 0) ? hist[t] : 1'b0;
    prv = (t >= 1) ? hist[t-1] : 1'b0;
    if (!running) begin
      if (cur && !prv) begin
        running = 1; r_t = t; fvalid = 0;
      end
    end else if (cur && !prv && fvalid) begin
      e_period = t - r_t; e_high = f_t - r_t; e_valid = 1; e_stuck = 0;
      r_t = t; fvalid = 0;
    end else if (!cur && prv && !fvalid) begin
      f_t = t; fvalid = 1;
    end else if (t - r_t >= MAXC) begin
      e_stuck = 1; e_lvl = cur; running = 0;
    end
  endtask

  task automatic step(input bit v, input bit r);
    pwm_in = v; rst = r; hist[m] = v;
    @(posedge clk); #1;
    model(r);
    check("cap_valid", 32'(cap_valid), 32'(e_valid));
    check("cap_period", 32'(cap_period), 32'(e_period));
    check("cap_high", 32'(cap_high), 32'(e_high));
    check("stuck", 32'(stuck), 32'(e_stuck));
    check("stuck_level", 32'(stuck_level), 32'(e_lvl));
    m++;
  endtask

  task automatic hold(input bit v, input int n);
    repeat (n) step(v, 1'b0);
  endtask

  task automatic wave(input int h, input int l, input int n);
    repeat (n) begin
      hold(1'b1, h);
      hold(1'b0, l);
    end
  endtask

  // Timer with period register 7 (8-cycle frame), output high while count < compare.
  task automatic timer(input int cmp, input int cycles);
    int tc = 0;
    repeat (cycles) begin
      step(bit'(tc < cmp), 1'b0);
      tc = (tc == 7) ? 0 : tc + 1;
    end
  endtask

  initial begin
    repeat (3) step(1'b0, 1'b1);
    hold(1'b0, 4);

    wave(3, 5, 6);
    check("steady_period", 32'(cap_period), 32'd8);
    check("steady_high", 32'(cap_high), 32'd3);

    wave(1, 1, 10);
    check("fast_period", 32'(cap_period), 32'd2);
    check("fast_high", 32'(cap_high), 32'd1);

    wave(4, 4, 3);
    hold(1'b1, 300);
    check("stuck_hi", 32'(stuck), 32'd1);
    check("stuck_hi_lvl", 32'(stuck_level), 32'd1);
    check("stuck_keep_period", 32'(cap_period), 32'd8);
    check("stuck_keep_high", 32'(cap_high), 32'd4);

    hold(1'b0, 6);
    wave(2, 6, 4);
    check("recover_stuck", 32'(stuck), 32'd0);
    check("recover_high", 32'(cap_high), 32'd2);

    // Reset in the middle of a high phase.
    wave(4, 4, 3);
    hold(1'b1, 3);
    step(1'b1, 1'b1);
    check("rst_period", 32'(cap_period), 32'd0);
    hold(1'b1, 2);
    hold(1'b0, 4);
    wave(5, 3, 3);
    check("post_rst_period", 32'(cap_period), 32'd8);
    check("post_rst_high", 32'(cap_high), 32'd5);

    timer(4, 80);
    check("tmr4_period", 32'(cap_period), 32'd8);
    check("tmr4_high", 32'(cap_high), 32'd4);
    timer(1, 80);
    check("tmr1_high", 32'(cap_high), 32'd1);
    timer(0, 300);
    check("tmr0_stuck", 32'(stuck), 32'd1);
    check("tmr0_lvl", 32'(stuck_level), 32'd0);
    timer(8, 300);
    check("tmr8_stuck", 32'(stuck), 32'd1);
    check("tmr8_lvl", 32'(stuck_level), 32'd1);
    timer(7, 80);
    check("tmr7_period", 32'(cap_period), 32'd8);
    check("tmr7_high", 32'(cap_high), 32'd7);

    for (int i = 0; i < 80; i++) begin
      if ($urandom_range(0, 19) == 0) step(1'b1, 1'b1);
      if ($urandom_range(0, 14) == 0) hold(bit'($urandom_range(0, 1)), $urandom_range(250, 300));
      else wave($urandom_range(1, 12), $urandom_range(1, 12), 1);
    end
    hold(1'b0, 20);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
